// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if: bundle of the command, result and reducer streams of the
// modular-exponentiation sequencer.
//
// Parameter: SIZE - operand width; reducer dividends are 2*SIZE wide.
//
// Valid/ready rule for every stream here: a transfer happens on the rising
// clk edge where the source's tvalid and the sink's tready are both high. A
// source that raises tvalid keeps tvalid and its data stable until that
// edge. The reducer streams carry no tready. The reducer captures on the
// first cycle with both dividend and divisor tvalid high. Its
// red_result_tvalid stays high until red_rst.
//
// Signals:
//   s_base/exp/mod_tdata, s_tvalid, s_tready : command stream (into sequencer)
//   m_tdata, m_tvalid, m_tready              : result stream (out of sequencer)
//   err_mod_zero                             : command had modulus 0, valid with m_tvalid
//   busy                                     : command accepted, result not yet taken
//   red_dividen_*, red_divisor_*             : operands to the shared modulo reducer
//   red_result_tdata/tvalid                  : remainder from the reducer
//   red_rst                                  : reducer restart
//   dbg_state                                : sequencer FSM state, for observation
interface modexp_ctrl_if #(
    parameter int SIZE = 64
);
    logic [SIZE-1:0]   s_base_tdata;
    logic [SIZE-1:0]   s_exp_tdata;
    logic [SIZE-1:0]   s_mod_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [SIZE-1:0]   m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              err_mod_zero;
    logic              busy;
    logic [2*SIZE-1:0] red_dividen_tdata;
    logic              red_dividen_tvalid;
    logic [SIZE-1:0]   red_divisor_tdata;
    logic              red_divisor_tvalid;
    logic [SIZE-1:0]   red_result_tdata;
    logic              red_result_tvalid;
    logic              red_rst;
    logic [2:0]        dbg_state;

    // Sequencer side.
    modport master (
        input  s_base_tdata, s_exp_tdata, s_mod_tdata, s_tvalid,
        output s_tready,
        output m_tdata, m_tvalid, err_mod_zero, busy,
        input  m_tready,
        output red_dividen_tdata, red_dividen_tvalid,
        output red_divisor_tdata, red_divisor_tvalid,
        input  red_result_tdata, red_result_tvalid,
        output red_rst, dbg_state
    );

    // Environment side: command source, result sink and reducer.
    modport slave (
        output s_base_tdata, s_exp_tdata, s_mod_tdata, s_tvalid,
        input  s_tready,
        input  m_tdata, m_tvalid, err_mod_zero, busy,
        output m_tready,
        input  red_dividen_tdata, red_dividen_tvalid,
        input  red_divisor_tdata, red_divisor_tvalid,
        output red_result_tdata, red_result_tvalid,
        input  red_rst, dbg_state
    );
endinterface

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: square-and-multiply sequencer computing base^exp mod m. It
// forms full-width products and hands each one to the shared modulo reducer.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset. The reducer is held in restart
//          while rst is high.
//   bus  - modexp_ctrl_if.master: command, result and reducer streams, plus
//          dbg_state.
//
// Macro MODEXP_EARLY_EXIT_EN:
//   Defined: variable time. MUL runs only for set exponent bits, and the
//     loop stops after the highest set bit. exp==0 finishes with no
//     reductions.
//   Undefined (default): constant time. SIZE iterations of MUL and SQR are
//     always issued. The MUL result is kept only for set exponent bits.
//
// Every reduction takes PREP (product register), ISSUE (one cycle of
// operand valid), WAIT (until the remainder is valid) and CAPTURE (write
// back and pulse red_rst).
module modexp_ctrl #(
    parameter int SIZE = 64
) (
    input  logic          clk,
    input  logic          rst,
    modexp_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREP    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Which reduction the PREP..CAPTURE sub-sequence is working on.
    typedef enum logic [1:0] {
        OP_BASE = 2'd0,   // B = base mod M
        OP_MUL  = 2'd1,   // R = R*B mod M
        OP_SQR  = 2'd2    // B = B*B mod M, then E >>= 1
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [SIZE-1:0]   r_q, r_d;
    logic [SIZE-1:0]   b_q, b_d;
    logic [SIZE-1:0]   e_q, e_d;
    logic [SIZE-1:0]   m_q, m_d;
    logic [2*SIZE-1:0] prod_q, prod_d;
    logic              err_q, err_d;
`ifndef MODEXP_EARLY_EXIT_EN
    localparam int IW = $clog2(SIZE);
    logic [IW-1:0]     it_q, it_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_BASE;
            r_q     <= '0;
            b_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
`ifndef MODEXP_EARLY_EXIT_EN
            it_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            r_q     <= r_d;
            b_q     <= b_d;
            e_q     <= e_d;
            m_q     <= m_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
`ifndef MODEXP_EARLY_EXIT_EN
            it_q    <= it_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        r_d     = r_q;
        b_d     = b_q;
        e_d     = e_q;
        m_d     = m_q;
        prod_d  = prod_q;
        err_d   = err_q;
`ifndef MODEXP_EARLY_EXIT_EN
        it_d    = it_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.s_tvalid) begin
                    // The base waits in B until OP_BASE reduces it in place.
                    m_d   = bus.s_mod_tdata;
                    b_d   = bus.s_base_tdata;
                    e_d   = bus.s_exp_tdata;
                    op_d  = OP_BASE;
                    err_d = (bus.s_mod_tdata == '0);
`ifndef MODEXP_EARLY_EXIT_EN
                    it_d  = '0;
`endif
                    if (bus.s_mod_tdata == '0) begin
                        r_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        // With M==1 every residue is 0, so start R at 0.
                        r_d = (bus.s_mod_tdata == SIZE'(1)) ? '0 : SIZE'(1);
`ifdef MODEXP_EARLY_EXIT_EN
                        state_d = (bus.s_exp_tdata == '0) ? S_DONE : S_PREP;
`else
                        state_d = S_PREP;
`endif
                    end
                end
            end
            S_PREP: begin
                case (op_q)
                    OP_MUL:  prod_d = {{SIZE{1'b0}}, r_q} * {{SIZE{1'b0}}, b_q};
                    OP_SQR:  prod_d = {{SIZE{1'b0}}, b_q} * {{SIZE{1'b0}}, b_q};
                    default: prod_d = {{SIZE{1'b0}}, b_q};
                endcase
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.red_result_tvalid) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_PREP;
                case (op_q)
                    OP_MUL: begin
                        // In constant-time mode MUL also runs for clear bits.
                        // The product is then dropped.
                        if (e_q[0]) r_d = bus.red_result_tdata;
`ifdef MODEXP_EARLY_EXIT_EN
                        // No square is needed after the highest set bit.
                        if (e_q[SIZE-1:1] == '0) state_d = S_DONE;
                        else                     op_d    = OP_SQR;
`else
                        op_d = OP_SQR;
`endif
                    end
                    OP_SQR: begin
                        b_d = bus.red_result_tdata;
                        e_d = e_q >> 1;
`ifdef MODEXP_EARLY_EXIT_EN
                        // e_q[1] is bit 0 of the shifted exponent.
                        op_d = e_q[1] ? OP_MUL : OP_SQR;
`else
                        if (it_q == IW'(SIZE - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            it_d = it_q + 1'b1;
                            op_d = OP_MUL;
                        end
`endif
                    end
                    default: begin
                        b_d = bus.red_result_tdata;
`ifdef MODEXP_EARLY_EXIT_EN
                        op_d = e_q[0] ? OP_MUL : OP_SQR;
`else
                        op_d = OP_MUL;
`endif
                    end
                endcase
            end
            S_DONE: begin
                if (bus.m_tready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are gated with rst so that they hold reset values during the
    // reset cycles, before the state register has been cleared.
    assign bus.s_tready           = (state_q == S_IDLE) && !rst;
    assign bus.busy               = (state_q != S_IDLE) && !rst;
    assign bus.m_tvalid           = (state_q == S_DONE) && !rst;
    assign bus.m_tdata            = r_q;
    assign bus.err_mod_zero       = err_q;
    assign bus.red_dividen_tdata  = prod_q;
    assign bus.red_divisor_tdata  = m_q;
    assign bus.red_dividen_tvalid = (state_q == S_ISSUE) && !rst;
    assign bus.red_divisor_tvalid = (state_q == S_ISSUE) && !rst;
    assign bus.red_rst            = rst || (state_q == S_CAPTURE);
    assign bus.dbg_state          = state_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: bench for modexp_ctrl. It includes a behavioural modulo
// reducer with random latency. Each accepted command pushes its expected
// result onto a queue. A monitor pops one entry per result handshake and
// compares it with the output.
module tb_modexp_ctrl;
    localparam int SIZE = 64;
    localparam int EW   = 1 + 8 + SIZE;   // {err, issue count, residue}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modexp_ctrl_if #(.SIZE(SIZE)) bus ();
    modexp_ctrl #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    int issue_cnt = 0;
    int lat_fixed = -1;     // -1: random reducer latency
    int rdy_mode  = 0;      // 0: random m_tready, otherwise driven by the main sequence

    task automatic check_word(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Reference: right-to-left binary exponentiation in wide arithmetic.
    function automatic logic [SIZE-1:0] ref_modexp(input logic [SIZE-1:0] base, input logic [SIZE-1:0] e,
                                                   input logic [SIZE-1:0] m);
        logic [2*SIZE-1:0] r, b, mm;
        if (m == '0) return '0;
        mm = {{SIZE{1'b0}}, m};
        r  = (2*SIZE)'(1) % mm;
        b  = {{SIZE{1'b0}}, base} % mm;
        for (int i = 0; i < SIZE; i++) begin
            if (e[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return r[SIZE-1:0];
    endfunction

    function automatic int ref_issues(input logic [SIZE-1:0] e, input logic [SIZE-1:0] m);
        if (m == '0) return 0;
`ifdef MODEXP_EARLY_EXIT_EN
        begin
            int pc;
            int msb;
            pc  = 0;
            msb = 0;
            if (e == '0) return 0;
            for (int i = 0; i < SIZE; i++) begin
                if (e[i]) begin
                    pc++;
                    msb = i;
                end
            end
            return 1 + pc + msb;
        end
`else
        return 1 + 2 * SIZE;
`endif
    endfunction

    // Drive one command. Call it just after a rising edge. It returns just
    // after the edge that accepted the command.
    task automatic send_cmd(input logic [SIZE-1:0] base, input logic [SIZE-1:0] e, input logic [SIZE-1:0] m);
        int t;
        t = 0;
        bus.s_base_tdata = base;
        bus.s_exp_tdata  = e;
        bus.s_mod_tdata  = m;
        bus.s_tvalid     = 1'b1;
        while (!bus.s_tready && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.s_tready) begin
            check_bit("cmd_accept_timeout", 1'b0, 1'b1);
            bus.s_tvalid = 1'b0;
            return;
        end
        exp_q.push_back({m == '0, 8'(ref_issues(e, m)), ref_modexp(base, e, m)});
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        check_word("drain_pending", SIZE'(exp_q.size()), '0);
    endtask

    // Reducer model, issue counter and result monitor. All three sample at
    // the falling edge, where the DUT outputs are settled.
    initial begin
        logic [EW-1:0] ent;
        bit red_busy;
        int red_cnt;
        red_busy = 1'b0;
        red_cnt  = 0;
        bus.red_result_tvalid = 1'b0;
        bus.red_result_tdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.red_rst) begin
                red_busy = 1'b0;
                bus.red_result_tvalid = 1'b0;
            end else begin
                if (red_busy && !bus.red_result_tvalid) begin
                    if (red_cnt == 0) bus.red_result_tvalid = 1'b1;
                    else              red_cnt--;
                end
                if (bus.red_dividen_tvalid && bus.red_divisor_tvalid) begin
                    issue_cnt++;
                    if (!red_busy) begin
                        red_busy = 1'b1;
                        bus.red_result_tdata = (bus.red_divisor_tdata == '0) ? '0 :
                            SIZE'(bus.red_dividen_tdata % {{SIZE{1'b0}}, bus.red_divisor_tdata});
                        red_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                        if (red_cnt == 0) bus.red_result_tvalid = 1'b1;
                    end
                end
            end
            if (bus.s_tvalid && bus.s_tready) issue_cnt = 0;
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_q.size() == 0) begin
                    check_bit("unexpected_result", 1'b1, 1'b0);
                end else begin
                    ent = exp_q.pop_front();
                    check_word("result_data", bus.m_tdata, ent[SIZE-1:0]);
                    check_bit("err_mod_zero", bus.err_mod_zero, ent[EW-1]);
                    check_word("reducer_issues", SIZE'(issue_cnt), SIZE'(ent[EW-2:SIZE]));
                end
            end
        end
    end

    // Random backpressure on the result stream.
    initial begin
        bus.m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) bus.m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SIZE-1:0] rb, re, rm, hd;
        int t;
        rst = 1'b1;
        bus.s_tvalid     = 1'b0;
        bus.s_base_tdata = '0;
        bus.s_exp_tdata  = '0;
        bus.s_mod_tdata  = '0;

        // Values held during reset.
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_s_tready", bus.s_tready, 1'b0);
        check_bit("rst_red_rst", bus.red_rst, 1'b1);
        check_bit("rst_m_tvalid", bus.m_tvalid, 1'b0);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_dividen_tvalid", bus.red_dividen_tvalid, 1'b0);
        check_bit("rst_divisor_tvalid", bus.red_divisor_tvalid, 1'b0);
        rst = 1'b0;
        #1;
        check_bit("post_rst_s_tready", bus.s_tready, 1'b1);
        check_word("post_rst_m_tdata", bus.m_tdata, '0);
        check_bit("post_rst_err", bus.err_mod_zero, 1'b0);
        check_bit("post_rst_red_rst", bus.red_rst, 1'b0);

        // Directed vectors.
        send_cmd(64'd4, 64'd13, 64'd497);
        send_cmd(64'd2, 64'd10, 64'd1000);
        send_cmd(64'd1000, 64'd1, 64'd7);
        send_cmd(64'd5, 64'd0, 64'd7);
        send_cmd(64'd123, 64'd45, 64'd1);
        send_cmd(64'd9, 64'd9, 64'd0);
        send_cmd(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC5);
        wait_drain();

        // Random commands with a mix of moduli and exponent sizes.
        for (int i = 0; i < 20; i++) begin
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       rm = '0;
                1:       rm = 64'd1;
                2, 3:    rm = SIZE'($urandom_range(2, 65535));
                default: rm = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0:       re = '0;
                1:       re = SIZE'($urandom_range(1, 255));
                default: re = {$urandom, $urandom};
            endcase
            send_cmd(rb, re, rm);
        end
        wait_drain();

        // Result held under backpressure, then a command arrives in the
        // release cycle.
        rdy_mode     = 1;
        bus.m_tready = 1'b0;
        send_cmd(64'd7, 64'd77, 64'd1000003);
        t = 0;
        while (!bus.m_tvalid && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check_bit("hold_m_tvalid_rise", bus.m_tvalid, 1'b1);
        hd = ref_modexp(64'd7, 64'd77, 64'd1000003);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_bit("hold_m_tvalid", bus.m_tvalid, 1'b1);
            check_word("hold_m_tdata", bus.m_tdata, hd);
            check_bit("hold_err", bus.err_mod_zero, 1'b0);
            check_bit("hold_s_tready", bus.s_tready, 1'b0);
        end
        bus.m_tready     = 1'b1;
        bus.s_base_tdata = 64'd2;
        bus.s_exp_tdata  = 64'd10;
        bus.s_mod_tdata  = 64'd1000;
        bus.s_tvalid     = 1'b1;
        check_bit("release_s_tready", bus.s_tready, 1'b0);
        @(posedge clk); #1;
        check_bit("after_release_s_tready", bus.s_tready, 1'b1);
        check_bit("after_release_busy", bus.busy, 1'b0);
        exp_q.push_back({1'b0, 8'(ref_issues(64'd10, 64'd1000)), ref_modexp(64'd2, 64'd10, 64'd1000)});
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        check_bit("accepted_busy", bus.busy, 1'b1);
        rdy_mode = 0;
        wait_drain();

        // Reset during WAIT of the third reduction.
        lat_fixed = 2;
        send_cmd(64'd7, 64'd200, 64'd1009);
        t = 0;
        while (issue_cnt < 3 && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check_word("abort_third_issue", SIZE'(issue_cnt), SIZE'(3));
        rst = 1'b1;
        #1;
        check_bit("abort_red_rst", bus.red_rst, 1'b1);
        check_bit("abort_m_tvalid", bus.m_tvalid, 1'b0);
        check_bit("abort_busy", bus.busy, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lat_fixed = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_bit("abort_no_output", bus.m_tvalid, 1'b0);
        end
        send_cmd(64'd3, 64'd5, 64'd13);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Square-and-multiply sequencer for the ElGamal datapath. Accepts a (base, exponent, modulus) command, computes base^exp mod m by repeatedly forming SIZE×SIZE products and handing them to the shared modulo reducer over AXI-stream. It restarts the reducer between operations and returns the final residue on an AXI-stream output. It sits between the key/cipher control logic and the modulo reducer.

## Interface
- SIZE, 64, operand width in bits; products are 2*SIZE.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_base_tdata  in  SIZE  base
- s_exp_tdata  in  SIZE  exponent
- s_mod_tdata  in  SIZE  modulus m
- s_tvalid  in  1  command valid
- s_tready  out  1  command accepted when high with s_tvalid
- m_tdata  out  SIZE  result
- m_tvalid  out  1  result valid
- m_tready  in  1  result consumer ready
- err_mod_zero  out  1  last command had m==0; valid with m_tvalid
- busy  out  1  high from command accept until result handshake
- red_dividen_tdata  out  2*SIZE  product to reducer
- red_dividen_tvalid  out  1  reducer dividend valid
- red_divisor_tdata  out  SIZE  modulus to reducer
- red_divisor_tvalid  out  1  reducer divisor valid
- red_result_tdata  in  SIZE  reducer remainder
- red_result_tvalid  in  1  reducer remainder valid; sticky until red_rst
- red_rst  out  1  reducer restart pulse

## Operation
Reducer contract:
- After a red_rst cycle, the reducer is idle.
- It captures operands on the first cycle with both tvalids high.
- red_result_tvalid stays high until the next red_rst.
- Reducer tready signals are not used.

Registers: R (accumulator), B (running square), E (exponent shift register), M.

States:
- IDLE: s_tready=1. On handshake, latch operands.
  - M==0: set err_mod_zero, R=0, go to DONE.
  - Otherwise: R = (M==1) ? 0 : 1, E = exp, go to RED_BASE.
- RED_BASE: reduce {0,base} into B.
- MUL: reduce R*B into R.
- SQR: reduce B*B into B, then E <= E>>1.
- DONE: m_tvalid=1, m_tdata=R. On m_tready, return to IDLE.

Reduction sub-sequence, shared by RED_BASE, MUL and SQR:
- ISSUE: drive both red_*_tvalid high for exactly one cycle, with the product registered the cycle before.
- WAIT: wait for red_result_tvalid.
- CAPTURE: write the result into the target register and pulse red_rst for that one cycle.

General rules:
- Products use full-width unsigned multiplication: {SIZE{0}} is never truncated, and both operands are < M.
- red_rst is also asserted while rst is high.
- Iteration loop: MUL then SQR per exponent bit, with ordering controlled by the configuration macro (see Configuration).

## Timing
Reset values:
- s_tready=0 during rst, 1 in the first cycle after rst deasserts.
- m_tvalid=0, m_tdata=0, err_mod_zero=0, busy=0.
- red_*_tvalid=0, red_rst=1 during rst.

Latency:
- Each reduction costs 3 + Lred cycles: product register, ISSUE, WAIT (Lred), CAPTURE.
- Command-to-m_tvalid latency = 1 + N·(3+Lred) + 1, where N is the reduction count.

Handshakes and boundaries:
- m_tdata and err_mod_zero are held stable while m_tvalid=1 and m_tready=0.
- A new command is not accepted in the same cycle as the result handshake; s_tready rises the next cycle.
- If rst is asserted mid-operation, all state is abandoned, the reducer is restarted, and no output is produced.
- If red_result_tvalid is already high on entry to WAIT (zero-latency reducer), capture happens the next cycle.

## Configuration
Macro: MODEXP_EARLY_EXIT_EN.

Defined (variable time):
- exp==0 (with M>1 or M==1) goes directly to DONE with no reductions.
- MUL runs only when E[0]==1.
- The loop ends once the remaining E is 0; no SQR is issued after the highest set bit.
- N = 1 + popcount(exp) + msb_index(exp).

Undefined (constant time):
- Exactly SIZE iterations. Each iteration always issues MUL then SQR.
- The MUL result is written to R only when E[0]==1; otherwise it is discarded.
- N = 1 + 2·SIZE, which is 129 for SIZE=64, regardless of exp.

## Test plan
- base=4, exp=13, m=497 -> m_tdata=445, err_mod_zero=0. Reducer-issue count = 7 with EN, 129 without (SIZE=64).
- base=2, exp=10, m=1000 -> 24. base=1000, exp=1, m=7 -> 6, exercising base ≥ m reduction.
- exp=0, m=7 -> 1. m=1, any base/exp -> 0. With EN, zero reducer issues for exp=0.
- m=0 -> err_mod_zero=1, m_tdata=0, no red_*_tvalid ever asserted.
- Hold m_tready=0 for 20 cycles after m_tvalid: check data is stable and s_tready=0. A command presented in the release cycle is accepted only the following cycle.
- Assert rst during WAIT of the 3rd reduction: check red_rst=1, m_tvalid stays 0, busy=0. The next command (3, 5, 13) returns 9.
